// File: rtl/snr_window_accumulator_if.sv
// Sample/result bundle between the SNR window accumulator and whatever drives it.
// No latency: plain wires grouped so the measurement block can be dropped in beside a filter.
// No backpressure: samples are taken whenever in_valid is high; optional peak_err needs PEAK_ERR_EN.
interface snr_window_accumulator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DUT_WIDTH  = 32,
    parameter int ACC_WIDTH  = 48
);
    logic                         start;
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] ref_in;
    logic signed [DUT_WIDTH-1:0]  dut_in;
    logic                         busy;
    logic                         done;
    logic [ACC_WIDTH-1:0]         sig_pow;
    logic [ACC_WIDTH-1:0]         err_pow;
    logic                         overflow;
`ifdef PEAK_ERR_EN
    logic [DATA_WIDTH:0]          peak_err;
`endif

    modport master (
        output start, in_valid, ref_in, dut_in,
        input  busy, done, sig_pow, err_pow, overflow
`ifdef PEAK_ERR_EN
        , input peak_err
`endif
    );

    modport slave (
        input  start, in_valid, ref_in, dut_in,
        output busy, done, sig_pow, err_pow, overflow
`ifdef PEAK_ERR_EN
        , output peak_err
`endif
    );
endinterface

// File: rtl/snr_window_accumulator.sv
// Accumulates ref^2 and (dut_scaled - delayed ref)^2 over 2^LOG2_WINDOW valid samples; PEAK_ERR_EN adds peak |err|.
// Latency: done pulses 2 cycles after the last counted valid sample; results update with done.
// No backpressure: every in_valid sample is consumed; gaps only stall counting, start ignored unless idle.
module snr_window_accumulator #(
    parameter int DATA_WIDTH  = 16,
    parameter int DUT_WIDTH   = 32,
    parameter int DUT_FRAC    = 15,
    parameter int ALIGN_DELAY = 4,
    parameter int LOG2_WINDOW = 10,
    parameter int ACC_WIDTH   = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    snr_window_accumulator_if.slave bus
);
    localparam int DS_W     = DATA_WIDTH + 1;
    localparam int ERR_W    = DATA_WIDTH + 2;
    localparam int SIG_SQ_W = 2 * DATA_WIDTH;
    localparam int ERR_SQ_W = 2 * ERR_W;
    // Wide enough that acc + square never wraps before the saturation test.
    localparam int SUM_W    = ACC_WIDTH + ERR_SQ_W + 1;
    localparam int WIN      = 1 << LOG2_WINDOW;
    localparam int CNT_W    = (LOG2_WINDOW + 1 > 7) ? LOG2_WINDOW + 1 : 7;
    localparam int DL_D     = (ALIGN_DELAY > 0) ? ALIGN_DELAY : 1;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};
    localparam logic signed [DUT_WIDTH-1:0] DS_MAX = {{(DUT_WIDTH-DS_W+1){1'b0}}, {(DS_W-1){1'b1}}};
    localparam logic signed [DUT_WIDTH-1:0] DS_MIN = {{(DUT_WIDTH-DS_W+1){1'b1}}, {(DS_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FILL, ACCUM, DONE} state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q;
    logic signed [DATA_WIDTH-1:0] dline_q [DL_D];
    logic signed [DATA_WIDTH-1:0] ref_d;
    logic signed [DUT_WIDTH-1:0]  dut_sh;
    logic signed [DS_W-1:0]       dut_s;
    logic signed [ERR_W-1:0]      err;
    logic signed [SIG_SQ_W-1:0]   sig_prod;
    logic signed [ERR_SQ_W-1:0]   err_prod;
    logic                         start_ok;
    logic                         count_acc;
    logic                         sq_vld, sq_last;
    logic [SIG_SQ_W-1:0]          sig_sq_q;
    logic [ERR_SQ_W-1:0]          err_sq_q;
    logic [ACC_WIDTH-1:0]         sig_acc_q, err_acc_q;
    logic                         ovf_q;
    logic [ACC_WIDTH:0]           sig_add, err_add;
    logic [ACC_WIDTH-1:0]         sig_pow_q, err_pow_q;
    logic                         overflow_q;

    // Saturating add; the top bit of the result flags that saturation happened.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ERR_SQ_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(ACC_MAX))
            return {1'b1, ACC_MAX};
        return {1'b0, s[ACC_WIDTH-1:0]};
    endfunction

    assign start_ok  = (state_q == IDLE) && bus.start;
    assign count_acc = (state_q == ACCUM) && bus.in_valid && (cnt_q < CNT_W'(WIN));

    // Reference delay line shifts on every valid sample regardless of measurement state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DL_D; i++) dline_q[i] <= '0;
        end else if (bus.in_valid) begin
            dline_q[0] <= bus.ref_in;
            for (int i = 1; i < DL_D; i++) dline_q[i] <= dline_q[i-1];
        end
    end

    generate
        if (ALIGN_DELAY == 0) begin : g_nodelay
            assign ref_d = bus.ref_in;
        end else begin : g_delay
            assign ref_d = dline_q[ALIGN_DELAY-1];
        end
    endgenerate

    // Rescale filter output to reference units, clamp, and form the error term.
    always_comb begin
        dut_sh = bus.dut_in >>> DUT_FRAC;
        if (dut_sh > DS_MAX)
            dut_s = {1'b0, {(DS_W-1){1'b1}}};
        else if (dut_sh < DS_MIN)
            dut_s = {1'b1, {(DS_W-1){1'b0}}};
        else
            dut_s = dut_sh[DS_W-1:0];
        err      = $signed({dut_s[DS_W-1], dut_s}) - $signed({{2{ref_d[DATA_WIDTH-1]}}, ref_d});
        sig_prod = SIG_SQ_W'(ref_d) * SIG_SQ_W'(ref_d);
        err_prod = ERR_SQ_W'(err) * ERR_SQ_W'(err);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state: FILL absorbs the alignment delay, ACCUM ends once the last square is being summed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = (ALIGN_DELAY == 0) ? ACCUM : FILL;
            FILL:  if (bus.in_valid && cnt_q == CNT_W'(ALIGN_DELAY - 1)) state_d = ACCUM;
            ACCUM: if (sq_vld && sq_last) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Valid-sample counter, reused for FILL and ACCUM; it parks at WIN once the window is full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (start_ok)
            cnt_q <= '0;
        else if (state_q == FILL && bus.in_valid)
            cnt_q <= (cnt_q == CNT_W'(ALIGN_DELAY - 1)) ? '0 : cnt_q + 1'b1;
        else if (count_acc)
            cnt_q <= cnt_q + 1'b1;
    end

    // First pipeline stage: register squares of counted samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_vld   <= 1'b0;
            sq_last  <= 1'b0;
            sig_sq_q <= '0;
            err_sq_q <= '0;
        end else begin
            sq_vld  <= count_acc;
            sq_last <= count_acc && (cnt_q == CNT_W'(WIN - 1));
            if (count_acc) begin
                sig_sq_q <= sig_prod;
                err_sq_q <= err_prod;
            end
        end
    end

    always_comb begin
        sig_add = sat_add(sig_acc_q, ERR_SQ_W'(sig_sq_q));
        err_add = sat_add(err_acc_q, err_sq_q);
    end

    // Second stage: saturating accumulation, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_acc_q <= '0;
            err_acc_q <= '0;
            ovf_q     <= 1'b0;
        end else if (start_ok) begin
            sig_acc_q <= '0;
            err_acc_q <= '0;
            ovf_q     <= 1'b0;
        end else if (sq_vld) begin
            sig_acc_q <= sig_add[ACC_WIDTH-1:0];
            err_acc_q <= err_add[ACC_WIDTH-1:0];
            ovf_q     <= ovf_q | sig_add[ACC_WIDTH] | err_add[ACC_WIDTH];
        end
    end

    // Result registers load alongside the final accumulate so they are valid while done is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_pow_q  <= '0;
            err_pow_q  <= '0;
            overflow_q <= 1'b0;
        end else if (start_ok) begin
            overflow_q <= 1'b0;
        end else if (sq_vld && sq_last) begin
            sig_pow_q  <= sig_add[ACC_WIDTH-1:0];
            err_pow_q  <= err_add[ACC_WIDTH-1:0];
            overflow_q <= ovf_q | sig_add[ACC_WIDTH] | err_add[ACC_WIDTH];
        end
    end

    assign bus.busy     = (state_q == FILL) || (state_q == ACCUM);
    assign bus.done     = (state_q == DONE);
    assign bus.sig_pow  = sig_pow_q;
    assign bus.err_pow  = err_pow_q;
    assign bus.overflow = overflow_q;

`ifdef PEAK_ERR_EN
    logic [ERR_W-1:0]      err_abs;
    logic [DATA_WIDTH:0]   err_abs_sat, abs_q, peak_acc_q, peak_next, peak_err_q;

    always_comb begin
        err_abs     = err[ERR_W-1] ? -err : err;
        err_abs_sat = err_abs[ERR_W-1] ? {(DATA_WIDTH+1){1'b1}} : err_abs[DATA_WIDTH:0];
        peak_next   = (abs_q > peak_acc_q) ? abs_q : peak_acc_q;
    end

    // Track the running peak |err| of counted samples; publish it with done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abs_q      <= '0;
            peak_acc_q <= '0;
            peak_err_q <= '0;
        end else begin
            if (count_acc) abs_q <= err_abs_sat;
            if (start_ok)
                peak_acc_q <= '0;
            else if (sq_vld)
                peak_acc_q <= peak_next;
            if (sq_vld && sq_last) peak_err_q <= peak_next;
        end
    end

    assign bus.peak_err = peak_err_q;
`endif
endmodule

// File: tb/tb_snr_window_accumulator.sv
// Directed bench for snr_window_accumulator: four instances (delay 0, 4, 3; narrow accumulator) share one stimulus.
// Inputs change 1 time unit after each rising edge and outputs are read at that same point.
// Checks cover reset, power sums, alignment, gap independence, done timing, saturation, reset abort, ignored start.
module tb_snr_window_accumulator;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic in_valid;
    logic signed [15:0] ref_v;
    logic signed [31:0] dut_v;

    int n_checks = 0;
    int n_fail   = 0;
    int done_a = 0, done_b = 0, done_c = 0, done_d = 0;

    always #5 clk = ~clk;

    snr_window_accumulator_if #(.DATA_WIDTH(16), .DUT_WIDTH(32), .ACC_WIDTH(48)) if_a ();
    snr_window_accumulator_if #(.DATA_WIDTH(16), .DUT_WIDTH(32), .ACC_WIDTH(48)) if_b ();
    snr_window_accumulator_if #(.DATA_WIDTH(16), .DUT_WIDTH(32), .ACC_WIDTH(48)) if_c ();
    snr_window_accumulator_if #(.DATA_WIDTH(16), .DUT_WIDTH(32), .ACC_WIDTH(24)) if_d ();

    assign if_a.start = start; assign if_a.in_valid = in_valid; assign if_a.ref_in = ref_v; assign if_a.dut_in = dut_v;
    assign if_b.start = start; assign if_b.in_valid = in_valid; assign if_b.ref_in = ref_v; assign if_b.dut_in = dut_v;
    assign if_c.start = start; assign if_c.in_valid = in_valid; assign if_c.ref_in = ref_v; assign if_c.dut_in = dut_v;
    assign if_d.start = start; assign if_d.in_valid = in_valid; assign if_d.ref_in = ref_v; assign if_d.dut_in = dut_v;

    snr_window_accumulator #(.ALIGN_DELAY(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    snr_window_accumulator #(.ALIGN_DELAY(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    snr_window_accumulator #(.ALIGN_DELAY(3)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
    snr_window_accumulator #(.ALIGN_DELAY(0), .ACC_WIDTH(24)) dut_d (.clk(clk), .rst(rst), .bus(if_d));

    // Count cycles with done high per instance; a stuck done shows up as an extra count.
    always @(posedge clk) begin
        if (if_a.done === 1'b1) done_a <= done_a + 1;
        if (if_b.done === 1'b1) done_b <= done_b + 1;
        if (if_c.done === 1'b1) done_c <= done_c + 1;
        if (if_d.done === 1'b1) done_d <= done_d + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sine(input int n);
        case (n % 8)
            0: return 0;
            1: return 7071;
            2: return 10000;
            3: return 7071;
            4: return 0;
            5: return -7071;
            6: return -10000;
            default: return -7071;
        endcase
    endfunction

    // Reference sample k of pattern p.
    function automatic int gen_r(input int p, input int k);
        case (p)
            0, 1:    return 100;
            2, 3:    return sine(k);
            default: return 32767;
        endcase
    endfunction

    // Filter-output sample k of pattern p, in Q15 relative to the reference.
    function automatic int gen_d(input int p, input int k);
        case (p)
            0:       return 100 * 32768;
            1:       return 103 * 32768;
            2:       return (k >= 4) ? sine(k - 4) * 32768 : 0;
            3:       return (sine(k) + 3) * 32768;
            default: return 32767 * 32768;
        endcase
    endfunction

    task automatic cyc(input logic s, input logic v, input int r, input int d);
        start    = s;
        in_valid = v;
        ref_v    = 16'(r);
        dut_v    = 32'(d);
        @(posedge clk);
        #1;
    endtask

    // Feed nvalid samples of pattern p (optionally 50% gapped); checks dut_a done timing around the 1024th valid.
    task automatic feed(input int p, input bit gap, input bit chk_a, input int nvalid, input int restart_at);
        int  k    = 0;
        int  c    = 0;
        bit  pend = 0;
        bit  v;
        while (k < nvalid) begin
            v = !(gap && (c % 2 == 0));
            if (v) cyc((k == restart_at) ? 1'b1 : 1'b0, 1'b1, gen_r(p, k), gen_d(p, k));
            else   cyc(1'b0, 1'b0, -1234, -12345 * 32768);
            c++;
            if (pend) begin
                chk("done_two_cycles_after_last", if_a.done, 1);
                chk("busy_low_in_done", if_a.busy, 0);
                pend = 0;
            end
            if (v) begin
                k++;
                if (k == 1024 && chk_a) begin
                    chk("done_not_yet_at_last", if_a.done, 0);
                    chk("busy_at_last", if_a.busy, 1);
                    pend = 1;
                end
            end
        end
        repeat (4) cyc(1'b0, 1'b0, 0, 0);
    endtask

    task automatic measure(input int p, input bit gap, input bit start_vld, input bit chk_a);
        // The start-cycle sample carries large values so any miscount is visible.
        cyc(1'b1, start_vld, 30000, 30000 * 32768);
        if (chk_a) chk("busy_after_start", if_a.busy, 1);
        feed(p, gap, chk_a, 1030, -1);
    endtask

    initial begin
        int da0;
        int dd0;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; ref_v = '0; dut_v = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", if_a.busy, 0);
        chk("reset_done", if_a.done, 0);
        chk("reset_sig_pow", if_a.sig_pow, 0);
        chk("reset_err_pow", if_a.err_pow, 0);
        chk("reset_overflow", if_a.overflow, 0);
        rst = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 0, 0);

        // Matched constant input; valid sample in start cycle must be skipped.
        da0 = done_a;
        measure(0, 1'b0, 1'b1, 1'b1);
        chk("t1_sig_pow", if_a.sig_pow, 64'd10240000);
        chk("t1_err_pow", if_a.err_pow, 64'd0);
        chk("t1_overflow", if_a.overflow, 0);
        chk("t1_done_once", 64'(done_a - da0), 64'd1);

        // Constant error of 3 LSB.
        measure(1, 1'b0, 1'b0, 1'b1);
        chk("t2_sig_pow", if_a.sig_pow, 64'd10240000);
        chk("t2_err_pow", if_a.err_pow, 64'd9216);
`ifdef PEAK_ERR_EN
        chk("t2_peak_err", if_a.peak_err, 64'd3);
`endif

        // Sine delayed by 4: correct alignment gives zero error, one short gives nonzero.
        measure(2, 1'b0, 1'b0, 1'b0);
        chk("t3_b_err_pow", if_b.err_pow, 64'd0);
        chk("t3_b_sig_pow", if_b.sig_pow, 64'd51199508992);
        chk("t3_c_err_nonzero", 64'(if_c.err_pow != 0), 64'd1);
        chk("t3_b_done_count", 64'(done_b), 64'd3);

        // Same sine data continuous and with 50% gaps.
        measure(3, 1'b0, 1'b0, 1'b1);
        chk("t4_cont_sig_pow", if_a.sig_pow, 64'd51199508992);
        chk("t4_cont_err_pow", if_a.err_pow, 64'd9216);
        measure(3, 1'b1, 1'b0, 1'b1);
        chk("t4_gap_sig_pow", if_a.sig_pow, 64'd51199508992);
        chk("t4_gap_err_pow", if_a.err_pow, 64'd9216);

        // Narrow accumulator saturates; the next start clears overflow.
        dd0 = done_d;
        measure(4, 1'b0, 1'b0, 1'b0);
        chk("t5_sig_pow_sat", if_d.sig_pow, 64'd16777215);
        chk("t5_overflow", if_d.overflow, 1);
        chk("t5_err_pow", if_d.err_pow, 64'd0);
        chk("t5_done_once", 64'(done_d - dd0), 64'd1);
        cyc(1'b1, 1'b0, 0, 0);
        chk("t5_overflow_cleared", if_d.overflow, 0);
        chk("t5_sig_pow_held", if_d.sig_pow, 64'd16777215);
        feed(0, 1'b0, 1'b0, 1030, -1);
        chk("t5_sig_pow_fit", if_d.sig_pow, 64'd10240000);
        chk("t5_overflow_clear", if_d.overflow, 0);

        // Asynchronous reset in the middle of ACCUM.
        da0 = done_a;
        cyc(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 500; i++) cyc(1'b0, 1'b1, 100, 103 * 32768);
        chk("t6_busy_mid", if_a.busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", if_a.busy, 0);
        chk("t6_rst_done", if_a.done, 0);
        chk("t6_rst_sig_pow", if_a.sig_pow, 0);
        chk("t6_rst_err_pow", if_a.err_pow, 0);
        chk("t6_rst_overflow", if_a.overflow, 0);
        rst = 1'b1;
        repeat (1100) cyc(1'b0, 1'b1, 100, 103 * 32768);
        chk("t6_no_done_after_abort", 64'(done_a - da0), 64'd0);
        chk("t6_idle_after_abort", if_a.busy, 0);

        // Start while busy is ignored: done timing and result follow the first start.
        da0 = done_a;
        cyc(1'b1, 1'b0, 0, 0);
        feed(1, 1'b0, 1'b1, 1030, 500);
        chk("t6_restart_sig_pow", if_a.sig_pow, 64'd10240000);
        chk("t6_restart_err_pow", if_a.err_pow, 64'd9216);
        chk("t6_restart_done_once", 64'(done_a - da0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
